uart_mbox_client: RTL

//  Core-side driver for a UART leaf on the AXI-MailboxFabric. Turns a local byte stream into
//  one-byte mailbox writes to the leaf's CSR0 (UART TX data). Receives the leaf's OPC_DATA
//  RX-byte packets into a local byte FIFO. Attaches to the core port of a mailbox_endpoint_stream.

---
 rtl/mailbox_pkg.sv | 8 +
 rtl/uart_mbox_client_if.sv | 13 +
 rtl/uart_client_rx_fifo.sv | 36 +++
 rtl/uart_mbox_client.sv | 101 ++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// mailbox_pkg: shared mailbox fabric constants plus the UART leaf CSR map and client FSM states.
package mailbox_pkg;
  localparam logic [3:0] OPC_DATA = 4'h1;
  localparam logic [3:0] UART_CSR_TXDATA = 4'd0;
  localparam logic [3:0] UART_CSR_DEST = 4'd2;
  localparam logic [3:0] UART_CSR_BAUD = 4'd3;
  typedef enum logic [1:0] {ST_INIT_DEST, ST_INIT_BAUD, ST_RUN} uart_client_state_e;
endpackage

// File: rtl/uart_mbox_client_if.sv
// uart_mbox_client_if: core port of a mailbox_endpoint_stream (tx beat out, rx beat in).
interface uart_mbox_client_if;
  logic tx_valid, tx_ready, tx_prio, tx_eop;
  logic [31:0] tx_data;
  logic [15:0] tx_dest_id;
  logic [3:0] tx_opcode;
  logic rx_valid, rx_ready, rx_error;
  logic [31:0] rx_data;
  modport master(output tx_valid, tx_data, tx_dest_id, tx_opcode, tx_prio, tx_eop, rx_ready,
                 input tx_ready, rx_valid, rx_data, rx_error);
  modport slave(input tx_valid, tx_data, tx_dest_id, tx_opcode, tx_prio, tx_eop, rx_ready,
                output tx_ready, rx_valid, rx_data, rx_error);
endinterface

// File: rtl/uart_client_rx_fifo.sv
// uart_client_rx_fifo: synchronous byte FIFO; a push while full is taken only alongside a pop.
module uart_client_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_mbox_client.sv
// uart_mbox_client: drives a UART leaf over the mailbox fabric; received bytes land in a local FIFO.
// Optional saturating tx/rx/drop counters are built when UART_CLIENT_STATS_EN is defined.
module uart_mbox_client
  import mailbox_pkg::*;
#(
  parameter logic [15:0] UART_NODE = 16'h00F0,
  parameter logic [15:0] SELF_ID = 16'h0010,
  parameter logic [31:0] BAUD_DIV = 32'd217,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  input  logic [31:0] cfg_baud_div_i,
  input  logic        cfg_reinit_i,
  output logic        init_done_o,
  output logic [15:0] stat_tx_cnt_o,
  output logic [15:0] stat_rx_cnt_o,
  output logic [15:0] stat_drop_cnt_o,
  uart_mbox_client_if.master ep
);
  localparam logic [1:0] S_INIT_DEST = 2'(ST_INIT_DEST);
  localparam logic [1:0] S_INIT_BAUD = 2'(ST_INIT_BAUD);
  localparam logic [1:0] S_RUN = 2'(ST_RUN);
  logic [1:0] state_q, state_d;
  logic [31:0] baud_q, tx_data_q, tx_data_d;
  logic [3:0] tx_csr_q, tx_csr_d;
  logic tx_valid_q, free, load, push, pop, full, empty;
  logic unused_rx;
  assign free = !tx_valid_q || ep.tx_ready;
  assign init_done_o = state_q == S_RUN;
  assign in_ready_o = init_done_o && free;
  always_comb begin
    load = free && (state_q != S_RUN || in_valid_i);
    tx_csr_d = state_q == S_INIT_DEST ? UART_CSR_DEST : state_q == S_INIT_BAUD ? UART_CSR_BAUD : UART_CSR_TXDATA;
    tx_data_d = state_q == S_INIT_DEST ? {16'h0, SELF_ID} : state_q == S_INIT_BAUD ? baud_q : {24'h0, in_data_i};
    state_d = cfg_reinit_i ? S_INIT_DEST
            : load && state_q == S_INIT_DEST ? S_INIT_BAUD
            : load && state_q == S_INIT_BAUD ? S_RUN : state_q;
  end
  // A held beat keeps draining across cfg_reinit, so nothing is lost or reordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT_DEST;
      baud_q <= BAUD_DIV;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      tx_csr_q <= '0;
    end else begin
      state_q <= state_d;
      tx_valid_q <= load || !free;
      if (load) tx_data_q <= tx_data_d;
      if (load) tx_csr_q <= tx_csr_d;
      if (cfg_reinit_i) baud_q <= cfg_baud_div_i;
    end
  end
  assign ep.tx_valid = tx_valid_q;
  assign ep.tx_data = tx_data_q;
  assign ep.tx_dest_id = {UART_NODE[15:4], tx_csr_q};
  assign ep.tx_opcode = OPC_DATA;
  assign ep.tx_prio = 1'b0;
  assign ep.tx_eop = 1'b1;
  assign ep.rx_ready = 1'b1;
  assign unused_rx = ^ep.rx_data[31:8];
  assign pop = !empty && out_ready_i;
  assign push = ep.rx_valid && !ep.rx_error && (!full || pop);
  assign out_valid_o = !empty;
  uart_client_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .data_i(ep.rx_data[7:0]),
    .data_o(out_data_o), .full_o(full), .empty_o(empty)
  );
`ifdef UART_CLIENT_STATS_EN
  logic [15:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;
  logic tx_fire, drop;
  assign tx_fire = tx_valid_q && ep.tx_ready && tx_csr_q == UART_CSR_TXDATA;
  assign drop = ep.rx_valid && !push;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'(tx_fire && !(&tx_cnt_q));
      rx_cnt_q <= rx_cnt_q + 16'(push && !(&rx_cnt_q));
      drop_cnt_q <= drop_cnt_q + 16'(drop && !(&drop_cnt_q));
    end
  end
  assign stat_tx_cnt_o = tx_cnt_q;
  assign stat_rx_cnt_o = rx_cnt_q;
  assign stat_drop_cnt_o = drop_cnt_q;
`else
  assign stat_tx_cnt_o = '0;
  assign stat_rx_cnt_o = '0;
  assign stat_drop_cnt_o = '0;
`endif
endmodule
